// File: rtl/bdi_line_compressor_if.sv
// Handshake bundle between the refill stream, the BDI compressor and the cache fill path.
// The compressor connects through the slave modport; the fill-side logic uses master.
interface bdi_line_compressor_if #(
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic [WORD_W-1:0]            in_word;
   logic                         out_valid;
   logic                         out_ready;
   logic [2:0]                   out_encoding;
   logic [5:0]                   out_size;
   logic [WORD_W*LINE_WORDS-1:0] out_data;

   modport master (
      output in_valid, in_word, out_ready,
      input  in_ready, out_valid, out_encoding, out_size, out_data
   );

   modport slave (
      input  in_valid, in_word, out_ready,
      output in_ready, out_valid, out_encoding, out_size, out_data
   );
endinterface

// File: rtl/bdi_line_compressor.sv
// Word-serial Base-Delta-Immediate compressor for one 8 x 32-bit cacheline.
// Define BDI_IMMEDIATE_EN to add the implicit zero base (per-width bases plus immediate mask).
module bdi_line_compressor #(
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   bdi_line_compressor_if.slave bus
);
   localparam int LINE_W = WORD_W * LINE_WORDS;

   localparam logic [2:0] ENC_ZEROS  = 3'd0;
   localparam logic [2:0] ENC_REPEAT = 3'd1;
   localparam logic [2:0] ENC_B4D1   = 3'd2;
   localparam logic [2:0] ENC_B4D2   = 3'd3;
   localparam logic [2:0] ENC_UNCOMP = 3'd4;

   typedef enum logic {ST_COLLECT, ST_OUTPUT} state_t;

   state_t     state;
   logic [2:0] cnt;
   logic       accept;
   logic       first;

   logic [WORD_W-1:0] word_p0 [LINE_WORDS];
   logic [7:0]        dl1_p0  [LINE_WORDS];
   logic [15:0]       dl2_p0  [LINE_WORDS];
   logic [WORD_W-1:0] base1_p0;
   logic              all_zero_p0, all_same_p0, fit1_p0, fit2_p0;

   logic [WORD_W-1:0]        base1_n, base2_n;
   logic                     all_zero_n, all_same_n, fit1_n, fit2_n;
   logic [7:0]               dl1_n;
   logic [15:0]              dl2_n;
   logic signed [WORD_W-1:0] diff1, diff2;
`ifdef BDI_IMMEDIATE_EN
   logic [WORD_W-1:0] base2_p0;
   logic              have1_p0, have2_p0, have1_n, have2_n;
   logic [7:0]        mask1_p0, mask2_p0, mask1_n, mask2_n;
`endif

   logic [WORD_W-1:0] line_w  [LINE_WORDS];
   logic [7:0]        line_d1 [LINE_WORDS];
   logic [15:0]       line_d2 [LINE_WORDS];
   logic [2:0]        enc_n;
   logic [5:0]        size_n;
   logic [LINE_W-1:0] data_n;

   // A value fits a width when it equals the sign extension of its own low bits.
   function automatic logic fits_s8(input logic signed [WORD_W-1:0] v);
      return v == {{(WORD_W-8){v[7]}}, v[7:0]};
   endfunction

   function automatic logic fits_s16(input logic signed [WORD_W-1:0] v);
      return v == {{(WORD_W-16){v[15]}}, v[15:0]};
   endfunction

   assign accept = bus.in_valid & bus.in_ready;
   assign first  = (cnt == 3'd0);

   always_comb begin
      all_zero_n = (first | all_zero_p0) & (bus.in_word == '0);
      all_same_n = first | (all_same_p0 & (bus.in_word == word_p0[0]));
`ifdef BDI_IMMEDIATE_EN
      have1_n = ~first & have1_p0;
      have2_n = ~first & have2_p0;
      base1_n = first ? '0 : base1_p0;
      base2_n = first ? '0 : base2_p0;
      mask1_n = first ? '0 : mask1_p0;
      mask2_n = first ? '0 : mask2_p0;
      fit1_n  = first | fit1_p0;
      fit2_n  = first | fit2_p0;
      diff1   = bus.in_word - base1_n;
      diff2   = bus.in_word - base2_n;
      dl1_n   = diff1[7:0];
      dl2_n   = diff2[15:0];
      if (fits_s8(bus.in_word)) begin
         mask1_n[cnt] = 1'b1;
         dl1_n        = bus.in_word[7:0];
      end else if (!have1_n) begin
         have1_n = 1'b1;
         base1_n = bus.in_word;
         dl1_n   = '0;
      end else begin
         fit1_n = fit1_n & fits_s8(diff1);
      end
      if (fits_s16(bus.in_word)) begin
         mask2_n[cnt] = 1'b1;
         dl2_n        = bus.in_word[15:0];
      end else if (!have2_n) begin
         have2_n = 1'b1;
         base2_n = bus.in_word;
         dl2_n   = '0;
      end else begin
         fit2_n = fit2_n & fits_s16(diff2);
      end
`else
      base1_n = first ? bus.in_word : base1_p0;
      base2_n = base1_n;
      diff1   = bus.in_word - base1_n;
      diff2   = diff1;
      fit1_n  = (first | fit1_p0) & fits_s8(diff1);
      fit2_n  = (first | fit2_p0) & fits_s16(diff2);
      dl1_n   = diff1[7:0];
      dl2_n   = diff2[15:0];
`endif
   end

   // Line view with the incoming word merged in; only meaningful when word 7 is accepted.
   always_comb begin
      for (int i = 0; i < LINE_WORDS; i++) begin
         line_w[i]  = (i == int'(cnt)) ? bus.in_word : word_p0[i];
         line_d1[i] = (i == int'(cnt)) ? dl1_n       : dl1_p0[i];
         line_d2[i] = (i == int'(cnt)) ? dl2_n       : dl2_p0[i];
      end
   end

   always_comb begin
      enc_n  = ENC_UNCOMP;
      size_n = 6'd32;
      data_n = '0;
      if (all_zero_n) begin
         enc_n  = ENC_ZEROS;
         size_n = 6'd0;
      end else if (all_same_n) begin
         enc_n            = ENC_REPEAT;
         size_n           = 6'd4;
         data_n[31:0]     = line_w[0];
      end else if (fit1_n) begin
         enc_n        = ENC_B4D1;
         data_n[31:0] = base1_n;
         for (int i = 0; i < LINE_WORDS; i++) data_n[32+8*i +: 8] = line_d1[i];
`ifdef BDI_IMMEDIATE_EN
         size_n              = 6'd13;
         data_n[LINE_W-1 -: 8] = mask1_n;
`else
         size_n = 6'd12;
`endif
      end else if (fit2_n) begin
         enc_n        = ENC_B4D2;
         data_n[31:0] = base2_n;
         for (int i = 0; i < LINE_WORDS; i++) data_n[32+16*i +: 16] = line_d2[i];
`ifdef BDI_IMMEDIATE_EN
         size_n              = 6'd21;
         data_n[LINE_W-1 -: 8] = mask2_n;
`else
         size_n = 6'd20;
`endif
      end else begin
         for (int i = 0; i < LINE_WORDS; i++) data_n[WORD_W*i +: WORD_W] = line_w[i];
      end
   end

   // Stage p0: per-word storage and running flags, captured on every accepted word.
   always_ff @(posedge clk) begin
      if (accept) begin
         word_p0[cnt] <= bus.in_word;
         dl1_p0[cnt]  <= dl1_n;
         dl2_p0[cnt]  <= dl2_n;
         base1_p0     <= base1_n;
         all_zero_p0  <= all_zero_n;
         all_same_p0  <= all_same_n;
         fit1_p0      <= fit1_n;
         fit2_p0      <= fit2_n;
`ifdef BDI_IMMEDIATE_EN
         base2_p0 <= base2_n;
         have1_p0 <= have1_n;
         have2_p0 <= have2_n;
         mask1_p0 <= mask1_n;
         mask2_p0 <= mask2_n;
`endif
      end
   end

   // Output stage: the compressed line is registered when word 7 is accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= ST_COLLECT;
         cnt              <= 3'd0;
         bus.in_ready     <= 1'b1;
         bus.out_valid    <= 1'b0;
         bus.out_encoding <= '0;
         bus.out_size     <= '0;
         bus.out_data     <= '0;
      end else begin
         case (state)
            ST_COLLECT: begin
               if (accept) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     state            <= ST_OUTPUT;
                     bus.in_ready     <= 1'b0;
                     bus.out_valid    <= 1'b1;
                     bus.out_encoding <= enc_n;
                     bus.out_size     <= size_n;
                     bus.out_data     <= data_n;
                  end
               end
            end
            ST_OUTPUT: begin
               if (bus.out_ready) begin
                  state         <= ST_COLLECT;
                  bus.in_ready  <= 1'b1;
                  bus.out_valid <= 1'b0;
               end
            end
            default: state <= ST_COLLECT;
         endcase
      end
   end
endmodule

// File: doc/bdi_line_compressor.md
# bdi_line_compressor

Word-serial Base-Delta-Immediate compressor for one 256-bit cacheline (8 × 32-bit words). It sits between the main-memory read stream and the cache fill path of the compressed cache system. It accepts the refill words one per handshake, classifies the line incrementally, and presents a packed compressed line with its encoding and byte size to the cache controller's write path.

## Interface
Parameters:
- WORD_W, 32, word width in bits (fixed; other values unsupported)
- LINE_WORDS, 8, words per cacheline (fixed)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  refill word valid
- in_ready  out  1  compressor can accept a word
- in_word  in  32  refill word; word index = internal count
- out_valid  out  1  compressed line available
- out_ready  in  1  consumer accepts the compressed line
- out_encoding  out  3  0 ZEROS, 1 REPEAT, 2 B4D1, 3 B4D2, 4 UNCOMP
- out_size  out  6  compressed payload size in bytes (0..32)
- out_data  out  256  packed payload, zero in unused bits

## Operation
- FSM with two states: COLLECT and OUTPUT.
- COLLECT: in_ready=1. Each in_valid&in_ready accepts in_word at index cnt (3-bit, 0..7).
- Word 0 captures base (non-immediate build). Accumulated flags, initialised by word 0 and ANDed by every later word: all_zero, all_same (== word 0), fit1 (word−base, mod 2^32, sign-extends from 8 bits), fit2 (same test from 16 bits). All 8 raw words are stored.
- Accepting word 7 moves the FSM to OUTPUT and resets cnt to 0.
- OUTPUT: in_ready=0, out_valid=1. Encoding priority: ZEROS > REPEAT > B4D1 > B4D2 > UNCOMP.
- Packing and size:
  - ZEROS: data 0, size 0.
  - REPEAT: word0 at [31:0], size 4.
  - B4D1: base at [31:0], delta i at [32+8i +:8], size 12.
  - B4D2: base at [31:0], delta i at [32+16i +:16], size 20.
  - UNCOMP: word i at [32i +:32], size 32.
- out_valid & out_ready returns the FSM to COLLECT. Flags and storage reinitialise on the next word 0.
- Delta arithmetic is 32-bit modular. The fit test requires bits [31:7] (fit1) or [31:15] (fit2) to be all equal.

## Timing
- Reset values: FSM=COLLECT, cnt=0, in_ready=1, out_valid=0, out_encoding=0, out_size=0, out_data=0.
- Throughput: one word per cycle while in_valid stays high.
- Latency: out_valid rises the cycle after word 7 is accepted (registered). A full line takes at least 9 cycles, plus one cycle for the out handshake.
- out_* are stable while out_valid=1 and out_ready=0. in_valid during OUTPUT is ignored (not accepted).
- Same-cycle out handshake: the FSM is in COLLECT the next cycle. No overlap with a new line's word 0 in the handshake cycle.
- Gaps on in_valid mid-line stall cnt with no loss of state.
- rst low mid-line or in OUTPUT: partial line discarded, reset values apply next cycle.

## Configuration
Macro BDI_IMMEDIATE_EN.
- Defined: implicit zero base is enabled.
  - Separate bases base1/base2 are kept for the 1-byte and 2-byte widths. Each is the first word that does not fit signed 8/16 bits from zero; it is 0 if no such word exists.
  - A word fits if it fits from zero (mask bit=1, preferred) or its delta from the width's base fits (mask bit=0).
  - The 8-bit mask goes at out_data[255:248] for B4D1/B4D2. Those sizes become 13 and 21.
  - Immediate words store their own low byte or halfword as the delta.
- Not defined: single base = word 0, no mask, [255:248] zero, sizes 12/20.

## Test plan
- All 8 words 0x00000000 -> encoding 0, size 0, out_data 0, out_valid on cycle 9.
- All words 0xDEADBEEF -> encoding 1, size 4, out_data[31:0]=0xDEADBEEF.
- Words 0x1000, 0x1001 … 0x1007 -> encoding 2, size 12, base 0x1000, deltas 0x00..0x07. Same words with word 3=0x0F00 -> encoding 3, delta3=0xFF00.
- Words 0x1000, 0x5, 0x1002, 0x7, 0x1004…0x1007:
  - Macro on -> encoding 2, size 13, mask 0x0A.
  - Macro off -> encoding 3, size 20.
- Alternating 0x0 and 0x80000000 -> encoding 4, size 32, raw words in order.
- Stall out_ready 5 cycles with in_valid high -> outputs stable, in_ready=0, no words consumed. Then assert rst low after 4 words of the next line -> out_valid=0, next 8 words form a fresh line.
